// File: rtl/f3_pkg.sv
// GF(3) digit encoding, default field size and shared helpers for the GF(3^M) blocks.
// Digits are 2-bit {hi,lo}: 00=0, 01=1, 10=2; 11 is never produced and treated as invalid.
package f3_pkg;

    localparam logic [1:0] F3_ZERO = 2'b00;
    localparam logic [1:0] F3_ONE  = 2'b01;
    localparam logic [1:0] F3_TWO  = 2'b10;

    localparam int F3M_M = 97;
    localparam int F3M_W = 2 * F3M_M;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } f3m_state_t;

    // Negation in GF(3) maps 1<->2 and 0->0, which is exactly a swap of the bit pair.
    function automatic logic [1:0] f3_neg(input logic [1:0] d);
        return {d[0], d[1]};
    endfunction

endpackage

// File: rtl/f3m_serial_addsub_if.sv
// Start/busy/done request interface for the digit-serial GF(3^M) add/sub unit.
// The scheduler side is the master; the arithmetic block is the slave.
interface f3m_serial_addsub_if import f3_pkg::*; #(
    parameter int M = F3M_M
);
    logic           start;
    logic           op;
    logic [2*M-1:0] A;
    logic [2*M-1:0] B;
    logic           busy;
    logic           done;
    logic [2*M-1:0] C;

    modport master (output start, output op, output A, output B,
                    input busy, input done, input C);
    modport slave  (input start, input op, input A, input B,
                    output busy, output done, output C);
endinterface

// File: rtl/f3m_addsub_slice.sv
// Combinational bank of D independent GF(3) digit adders; no carries between digits.
// Invalid operand digits (11) produce a zero sum digit.
module f3_digit_add import f3_pkg::*; (
    input  logic [1:0] a,
    input  logic [1:0] b,
    output logic [1:0] s
);
    always_comb begin
        s = F3_ZERO;
        case ({a, b})
            4'b00_00: s = F3_ZERO;
            4'b00_01: s = F3_ONE;
            4'b00_10: s = F3_TWO;
            4'b01_00: s = F3_ONE;
            4'b01_01: s = F3_TWO;
            4'b01_10: s = F3_ZERO;
            4'b10_00: s = F3_TWO;
            4'b10_01: s = F3_ZERO;
            4'b10_10: s = F3_ONE;
            default:  s = F3_ZERO;
        endcase
    end
endmodule

module f3m_addsub_slice #(
    parameter int D = 4
) (
    input  logic [2*D-1:0] a,
    input  logic [2*D-1:0] b,
    output logic [2*D-1:0] s
);
    for (genvar i = 0; i < D; i++) begin : g_cell
        f3_digit_add u_add (
            .a (a[2*i +: 2]),
            .b (b[2*i +: 2]),
            .s (s[2*i +: 2])
        );
    end
endmodule

// File: rtl/f3m_serial_addsub.sv
// Digit-serial GF(3^M) add/sub: C = A + B (op=0) or A - B (op=1), D digits per cycle, N = ceil(M/D) cycles.
// Starts are ignored while busy; done pulses for one cycle and C holds until the next completion.
module f3m_serial_addsub import f3_pkg::*; #(
    parameter int M = F3M_M,
    parameter int D = 4
) (
    input  logic                clk,
    input  logic                reset,
    f3m_serial_addsub_if.slave  io
);
    localparam int N  = (M + D - 1) / D;
    localparam int PW = 2 * D * N;
    localparam int CW = $clog2(N + 1);

    f3m_state_t     state_q, state_d;
    logic [CW-1:0]  cnt_q;
    logic [PW-1:0]  a_sr, b_sr, res_sr;
    logic [PW-1:0]  a_pad, b_pad, sum_ext, res_nxt;
    logic [2*D-1:0] sum;
    logic [2*M-1:0] c_q;
    logic           done_q;
    logic           accept, last;

    // Subtraction is folded into the latch: B digits are negated once on accept.
    always_comb begin
        a_pad = '0;
        b_pad = '0;
        a_pad[2*M-1:0] = io.A;
        for (int i = 0; i < M; i++) begin
            b_pad[2*i +: 2] = io.op ? f3_neg(io.B[2*i +: 2]) : io.B[2*i +: 2];
        end
    end

    f3m_addsub_slice #(.D(D)) u_slice (
        .a (a_sr[2*D-1:0]),
        .b (b_sr[2*D-1:0]),
        .s (sum)
    );

    // New sum digits enter at the top; after N shifts group 0 sits at bit 0.
    always_comb begin
        sum_ext = '0;
        sum_ext[PW-1 -: 2*D] = sum;
        res_nxt = (res_sr >> (2 * D)) | sum_ext;
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        last    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (io.start) begin
                    state_d = ST_RUN;
                    accept  = 1'b1;
                end
            end
            ST_RUN: begin
                if (cnt_q == CW'(N - 1)) begin
                    state_d = ST_IDLE;
                    last    = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= '0;
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            c_q    <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= last;
            if (accept) begin
                a_sr   <= a_pad;
                b_sr   <= b_pad;
                res_sr <= '0;
                cnt_q  <= '0;
            end else if (state_q == ST_RUN) begin
                a_sr   <= a_sr >> (2 * D);
                b_sr   <= b_sr >> (2 * D);
                res_sr <= res_nxt;
                cnt_q  <= last ? '0 : cnt_q + CW'(1);
                if (last) begin
                    c_q <= res_nxt[2*M-1:0];
                end
            end
        end
    end

    assign io.busy = (state_q == ST_RUN);
    assign io.done = done_q;
    assign io.C    = c_q;

endmodule

// File: tb/tb_f3m_serial_addsub.sv
// Directed and random checks of f3m_serial_addsub across four M/D configurations.
// Expected results come from an integer mod-3 reference model via a scoreboard queue.
module tb_f3m_serial_addsub;
    import f3_pkg::*;

    localparam int W = 194;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    f3m_serial_addsub_if #(.M(97)) if0 ();
    f3m_serial_addsub_if #(.M(5))  if1 ();
    f3m_serial_addsub_if #(.M(97)) if2 ();
    f3m_serial_addsub_if #(.M(97)) if3 ();

    f3m_serial_addsub #(.M(97), .D(4))  dut0 (.clk(clk), .reset(reset), .io(if0));
    f3m_serial_addsub #(.M(5),  .D(2))  dut1 (.clk(clk), .reset(reset), .io(if1));
    f3m_serial_addsub #(.M(97), .D(1))  dut2 (.clk(clk), .reset(reset), .io(if2));
    f3m_serial_addsub #(.M(97), .D(97)) dut3 (.clk(clk), .reset(reset), .io(if3));

    int n_cmp = 0;
    int n_err = 0;
    logic [W-1:0] exp_q[$];

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic logic [W-1:0] ref_model(input logic [W-1:0] a, input logic [W-1:0] b, input logic op);
        logic [W-1:0] r;
        int va, vb;
        r = '0;
        for (int i = 0; i < 97; i++) begin
            va = int'(a[2*i +: 2]);
            vb = int'(b[2*i +: 2]);
            if (va == 3 || vb == 3) r[2*i +: 2] = 2'd0;
            else if (op)            r[2*i +: 2] = 2'((va - vb + 3) % 3);
            else                    r[2*i +: 2] = 2'((va + vb) % 3);
        end
        return r;
    endfunction

    function automatic logic [W-1:0] rand_elem(input int m, input int maxd);
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < m; i++) r[2*i +: 2] = 2'($urandom_range(0, maxd));
        return r;
    endfunction

    function automatic logic get_done(input int s);
        case (s)
            0: return if0.done;
            1: return if1.done;
            2: return if2.done;
            default: return if3.done;
        endcase
    endfunction

    function automatic logic get_busy(input int s);
        case (s)
            0: return if0.busy;
            1: return if1.busy;
            2: return if2.busy;
            default: return if3.busy;
        endcase
    endfunction

    function automatic logic [W-1:0] get_c(input int s);
        case (s)
            0: return if0.C;
            1: return {{(W-10){1'b0}}, if1.C};
            2: return if2.C;
            default: return if3.C;
        endcase
    endfunction

    task automatic set_in(input int s, input logic st, input logic op, input logic [W-1:0] a, input logic [W-1:0] b);
        case (s)
            0: begin if0.start = st; if0.op = op; if0.A = a; if0.B = b; end
            1: begin if1.start = st; if1.op = op; if1.A = a[9:0]; if1.B = b[9:0]; end
            2: begin if2.start = st; if2.op = op; if2.A = a; if2.B = b; end
            default: begin if3.start = st; if3.op = op; if3.A = a; if3.B = b; end
        endcase
    endtask

    // Drives start for one edge from a negedge; returns at the following negedge.
    task automatic issue(input int s, input logic [W-1:0] a, input logic [W-1:0] b, input logic op, input logic push);
        set_in(s, 1'b1, op, a, b);
        if (push) exp_q.push_back(ref_model(a, b, op));
        @(posedge clk);
        @(negedge clk);
        set_in(s, 1'b0, ~op, ~a, ~b);
    endtask

    task automatic wait_done(input int s, input int n_exp, input string tag,
                             input logic hold_chk, input logic [W-1:0] hold_val);
        int cnt;
        logic seen;
        logic [W-1:0] e;
        cnt = 0;
        seen = 1'b0;
        while (!seen && cnt < 300) begin
            @(posedge clk);
            cnt++;
            @(negedge clk);
            if (get_done(s)) seen = 1'b1;
            else begin
                check({tag, "_busy"}, W'(get_busy(s)), W'(1));
                if (hold_chk) check({tag, "_hold"}, get_c(s), hold_val);
            end
        end
        check({tag, "_seen"}, W'(seen), W'(1));
        if (seen) begin
            check({tag, "_lat"}, W'(cnt), W'(n_exp));
            check({tag, "_busy_at_done"}, W'(get_busy(s)), W'(0));
            check({tag, "_q_nonempty"}, W'(exp_q.size() != 0), W'(1));
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check({tag, "_c"}, get_c(s), e);
            end
        end else if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
        end
    endtask

    logic [W-1:0] a, b, first_c, c_pre;
    logic op;
    int ndone;
    int nlat[4] = '{25, 3, 97, 1};

    initial begin
        for (int s = 0; s < 4; s++) set_in(s, 1'b0, 1'b0, '0, '0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Idle after reset
        for (int i = 0; i < 5; i++) begin
            for (int s = 0; s < 4; s++) begin
                check($sformatf("idle_busy_s%0d", s), W'(get_busy(s)), W'(0));
                check($sformatf("idle_done_s%0d", s), W'(get_done(s)), W'(0));
                check($sformatf("idle_c_s%0d", s), get_c(s), '0);
            end
            @(negedge clk);
        end

        // Add all ones
        a = {97{2'b01}};
        issue(0, a, a, 1'b0, 1'b1);
        wait_done(0, 25, "add_ones", 1'b0, '0);
        check("add_ones_const", get_c(0), {97{2'b10}});
        @(negedge clk);
        check("done_one_cycle", W'(get_done(0)), W'(0));
        check("c_held_after_done", get_c(0), {97{2'b10}});

        // Subtract all twos minus all ones
        issue(0, {97{2'b10}}, {97{2'b01}}, 1'b1, 1'b1);
        wait_done(0, 25, "sub_21", 1'b0, '0);
        check("sub_21_const", get_c(0), {97{2'b01}});

        // A - A = 0
        a = rand_elem(97, 2);
        issue(0, a, a, 1'b1, 1'b1);
        wait_done(0, 25, "sub_self", 1'b0, '0);
        check("sub_self_zero", get_c(0), '0);

        // Padding config M=5 D=2
        a = {{(W-10){1'b0}}, 10'b10_01_00_10_01};
        b = {{(W-10){1'b0}}, 10'b01_01_10_10_00};
        issue(1, a, b, 1'b0, 1'b1);
        wait_done(1, 3, "m5_add", 1'b0, '0);
        check("m5_const", get_c(1), {{(W-10){1'b0}}, 10'b00_10_10_01_01});

        // Start while busy is ignored
        a = rand_elem(97, 2);
        b = rand_elem(97, 2);
        issue(0, a, b, 1'b0, 1'b1);
        issue(0, rand_elem(97, 2), rand_elem(97, 2), 1'b1, 1'b0);
        wait_done(0, 24, "busy_ignore", 1'b0, '0);
        first_c = ref_model(a, b, 1'b0);

        // Start on the done cycle; C holds the first result meanwhile
        c_pre = get_c(0);
        a = rand_elem(97, 2);
        b = rand_elem(97, 2);
        issue(0, a, b, 1'b1, 1'b1);
        check("b2b_done_dropped", W'(get_done(0)), W'(0));
        check("b2b_hold_first", get_c(0), first_c);
        wait_done(0, 25, "b2b", 1'b1, c_pre);

        // Reset on compute cycle 10
        issue(0, rand_elem(97, 2), rand_elem(97, 2), 1'b0, 1'b1);
        repeat (9) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        void'(exp_q.pop_back());
        check("rst_mid_busy", W'(get_busy(0)), W'(0));
        check("rst_mid_done", W'(get_done(0)), W'(0));
        check("rst_mid_c", get_c(0), '0);
        ndone = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (get_done(0)) ndone++;
        end
        check("rst_no_done", W'(ndone), W'(0));
        check("rst_c_still_zero", get_c(0), '0);
        a = rand_elem(97, 2);
        b = rand_elem(97, 2);
        issue(0, a, b, 1'b1, 1'b1);
        wait_done(0, 25, "after_rst", 1'b0, '0);

        // Random operands, including invalid digits, across D = 4, 1, 97
        for (int s = 0; s < 4; s++) begin
            if (s == 1) continue;
            for (int k = 0; k < 3; k++) begin
                a = rand_elem(97, (k == 2) ? 3 : 2);
                b = rand_elem(97, (k == 2) ? 3 : 2);
                op = 1'($urandom_range(0, 1));
                issue(s, a, b, op, 1'b1);
                wait_done(s, nlat[s], $sformatf("rand_s%0d_k%0d", s, k), 1'b0, '0);
            end
        end

        check("queue_drained", W'(exp_q.size()), W'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
